// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults and elaboration helpers for the pipelined mux tree
package mux_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_IN = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/mux_tree_pipe_if.sv
// mux_tree_pipe_if: valid/ready input and output channels of the mux tree pipe
interface mux_tree_pipe_if import mux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN = DEF_N_IN,
  localparam int SEL_W = clog2(N_IN)
);
  logic in_valid;
  logic in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [N_IN*WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_sel;
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    input in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux2_w.sv
// mux2_w: width-parametrised combinational 2:1 cell
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N_IN:1 binary mux tree with one register stage per level and valid/ready flow
module mux_tree_pipe import mux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN = DEF_N_IN,
  localparam int SEL_W = clog2(N_IN)
) (
  input logic clk,
  input logic rst_n,
  mux_tree_pipe_if.slave bus
);
  logic stall;
  if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0) begin : g_chk
    $error("mux_tree_pipe: N_IN must be a power of two >= 2");
  end
  assign stall = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int NO = N_IN >> (l + 1);
    logic [2*NO*WIDTH-1:0] src;
    logic [NO*WIDTH-1:0] mux;
    logic [NO*WIDTH-1:0] q;
    logic [SEL_W-1:0] ssrc;
    logic [SEL_W-1:0] sq;
    logic vsrc;
    logic vq;
    if (l == 0) begin : g_first
      assign src = bus.in_data;
      assign ssrc = bus.in_sel;
      assign vsrc = bus.in_valid;
    end else begin : g_next
      assign src = g_lvl[l-1].q;
      assign ssrc = g_lvl[l-1].sq;
      assign vsrc = g_lvl[l-1].vq;
    end
    for (genvar c = 0; c < NO; c++) begin : g_cell
      mux2_w #(.WIDTH(WIDTH)) u_mux (
        .a(src[slice_lo(2*c, WIDTH) +: WIDTH]),
        .b(src[slice_lo(2*c+1, WIDTH) +: WIDTH]),
        .sel(ssrc[l]),
        .y(mux[slice_lo(c, WIDTH) +: WIDTH])
      );
    end
    // Data registers clock even for invalid slots; only a stall freezes them.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        q <= '0;
        sq <= '0;
        vq <= 1'b0;
      end else if (!stall) begin
        q <= mux;
        sq <= ssrc;
        vq <= vsrc;
      end
  end
  assign bus.out_valid = g_lvl[SEL_W-1].vq;
  assign bus.out_data = g_lvl[SEL_W-1].q;
  assign bus.out_sel = g_lvl[SEL_W-1].sq;
endmodule
